// File: rtl/i2c_slave_rx_ctrl.sv
// Write-only I2C slave receive controller: oversamples SCL/SDA in the system
// clock domain, tracks bus framing, ACKs its address and hands bytes to the core.
module i2c_slave_rx_ctrl #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       shift_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       addr_match,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_e;

  // Progress through the ACK slot: first SCL fall, 9th rise, closing fall.
  typedef enum logic [1:0] {
    PH_WAIT_FALL, PH_DRIVE, PH_HOLD
  } ack_ph_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   bus_start, bus_stop;

  state_e     state_q, state_d;
  ack_ph_e    ack_ph_q, ack_ph_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shadow_q, shadow_d, shadow_next;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       shift_en_q, shift_en_d;
  logic       busy_q, busy_d;
  logic       addr_match_q, addr_match_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign sda_rise  = sda_s & ~sda_prev_q;
  assign sda_fall  = ~sda_s & sda_prev_q;
  assign bus_start = sda_fall & scl_s;
  assign bus_stop  = sda_rise & scl_s;
  assign shadow_next = {shadow_q[6:0], sda_s};

  // Handshake: rx_valid=1 means rx_data holds an unconsumed byte; the byte is
  // taken on any clk edge where rx_valid & rx_ready, and rx_valid drops after it.
  always_comb begin
    state_d      = state_q;
    ack_ph_d     = ack_ph_q;
    bit_cnt_d    = bit_cnt_q;
    shadow_d     = shadow_q;
    ack_d        = ack_q;
    sda_oe_d     = sda_oe_q;
    shift_en_d   = shift_en_q;
    busy_d       = busy_q;
    addr_match_d = addr_match_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;
    overrun_d    = 1'b0;

    if (bus_stop) begin
      state_d      = S_IDLE;
      bit_cnt_d    = 3'd0;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
      shift_en_d   = 1'b0;
      sda_oe_d     = 1'b0;
    end else if (bus_start) begin
      state_d      = S_ADDR;
      ack_ph_d     = PH_WAIT_FALL;
      bit_cnt_d    = 3'd0;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
      shift_en_d   = 1'b1;
      sda_oe_d     = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_DATA: begin
          if (scl_rise) begin
            shadow_d = shadow_next;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              shift_en_d = 1'b0;
              ack_ph_d   = PH_WAIT_FALL;
              if (state_q == S_ADDR) begin
                state_d = S_ADDR_ACK;
                ack_d   = (shadow_next[7:1] == DEV_ADDR) && !shadow_next[0];
              end else begin
                state_d = S_DATA_ACK;
                // A still-pending byte cannot be overwritten: refuse the new one.
                if (!rx_valid_q) begin
                  ack_d      = 1'b1;
                  rx_data_d  = shadow_next;
                  rx_valid_d = 1'b1;
                end else begin
                  ack_d     = 1'b0;
                  overrun_d = 1'b1;
                end
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (scl_fall && ack_ph_q == PH_WAIT_FALL) begin
            sda_oe_d = ack_q;
            ack_ph_d = PH_DRIVE;
          end else if (scl_rise && ack_ph_q == PH_DRIVE) begin
            ack_ph_d = PH_HOLD;
          end else if (scl_fall && ack_ph_q == PH_HOLD) begin
            sda_oe_d = 1'b0;
            ack_ph_d = PH_WAIT_FALL;
            if (ack_q) begin
              state_d      = S_DATA;
              bit_cnt_d    = 3'd0;
              shift_en_d   = 1'b1;
              addr_match_d = 1'b1;
            end else begin
              state_d    = S_IGNORE;
              shift_en_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      ack_ph_q     <= PH_WAIT_FALL;
      bit_cnt_q    <= 3'd0;
      shadow_q     <= 8'h00;
      ack_q        <= 1'b0;
      sda_oe_q     <= 1'b0;
      shift_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      addr_match_q <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_s;
      sda_prev_q   <= sda_s;
      state_q      <= state_d;
      ack_ph_q     <= ack_ph_d;
      bit_cnt_q    <= bit_cnt_d;
      shadow_q     <= shadow_d;
      ack_q        <= ack_d;
      sda_oe_q     <= sda_oe_d;
      shift_en_q   <= shift_en_d;
      busy_q       <= busy_d;
      addr_match_q <= addr_match_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign shift_en   = shift_en_q;
  assign busy       = busy_q;
  assign addr_match = addr_match_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign overrun    = overrun_q;

endmodule
